// File: rtl/seq_counter.sv
// seq_counter: enabled counter with runtime-selectable up/down/Gray/LFSR sequence, load and wrap pulse
module seq_counter #(
  parameter int WIDTH = 3,
  parameter int MOD = 6,
  parameter logic [WIDTH-1:0] TAPS = 3'b110
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MODW = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] TOP  = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  logic [WIDTH-1:0] inc, nxt;
  always_comb begin
    inc = gray2bin(q) + ONE;
    nxt = mode == 2'd0 ? (q >= LAST ? '0 : q + ONE)
        : mode == 2'd1 ? ((q == '0 || {1'b0, q} >= MODW) ? LAST : q - ONE)
        : mode == 2'd2 ? (inc ^ (inc >> 1))
        : (q == '0 ? ONE : {q[WIDTH-2:0], ^(q & TAPS)});
    tc = mode == 2'd0 ? (q == LAST) : mode == 2'd1 ? (q == '0) : (q == TOP);
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q <= load_val;
      wrap <= 1'b0;
    end else if (en) begin
      q <= nxt;
      wrap <= tc;
    end else begin
      wrap <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_counter.sv
// tb_seq_counter: checks seq_counter against a table-driven sequence model plus hand-computed vectors
module tb_seq_counter;
  localparam int W = 3;
  localparam int MOD = 6;
  logic clk = 0, clear = 0, en = 0, load = 0;
  logic [W-1:0] load_val = '0;
  logic [1:0] mode = '0;
  logic [W-1:0] q;
  logic tc, wrap;
  int pass = 0, total = 0;
  bit started = 0;
  int mq = 0, mw = 0;
  int lfsr_seq[7] = '{1, 2, 5, 3, 7, 6, 4};

  seq_counter #(.WIDTH(W), .MOD(MOD), .TAPS(3'b110)) dut (
    .clk(clk), .clear(clear), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .q(q), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic int gray_of(input int i);
    return i ^ (i >> 1);
  endfunction

  function automatic int gray_idx(input int v);
    for (int i = 0; i < 8; i++) if (gray_of(i) == v) return i;
    return 0;
  endfunction

  function automatic int lfsr_pos(input int v);
    for (int i = 0; i < 7; i++) if (lfsr_seq[i] == v) return i;
    return 0;
  endfunction

  function automatic int m_next(input int v, input int m);
    case (m)
      0: return v >= MOD - 1 ? 0 : v + 1;
      1: return (v == 0 || v >= MOD) ? MOD - 1 : v - 1;
      2: return gray_of((gray_idx(v) + 1) % 8);
      default: return v == 0 ? 1 : lfsr_seq[(lfsr_pos(v) + 1) % 7];
    endcase
  endfunction

  function automatic int m_tc(input int v, input int m);
    case (m)
      0: return int'(v == MOD - 1);
      1: return int'(v == 0);
      2: return int'(gray_idx(v) == 7);
      default: return int'(v != 0 && lfsr_seq[(lfsr_pos(v) + 1) % 7] == 1);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (clear) begin
      mq = 0;
      mw = 0;
      started = 1;
    end else if (load) begin
      mq = int'(load_val);
      mw = 0;
    end else if (en) begin
      mw = m_tc(mq, int'(mode));
      mq = m_next(mq, int'(mode));
    end else mw = 0;
  end

  always @(posedge clk) begin
    #1;
    if (started) begin
      chk("model_q", 32'(q), 32'(mq));
      chk("model_tc", 32'(tc), 32'(m_tc(mq, int'(mode))));
      chk("model_wrap", 32'(wrap), 32'(mw));
    end
  end

  task automatic step(input logic c, input logic l, input logic [W-1:0] lv, input logic e, input logic [1:0] m);
    @(negedge clk);
    clear = c; load = l; load_val = lv; en = e; mode = m;
    @(posedge clk);
    #2;
  endtask

  task automatic run(input string name, input logic [1:0] m, input int n, input int e[9], input logic [8:0] w, input int tcv);
    step(1, 0, 0, 1, m);
    chk({name, "_q0"}, 32'(q), 32'(e[0]));
    chk({name, "_wrap0"}, 32'(wrap), 0);
    for (int i = 1; i < n; i++) begin
      step(0, 0, 0, 1, m);
      chk({name, "_q"}, 32'(q), 32'(e[i]));
      chk({name, "_wrap"}, 32'(wrap), 32'(w[i]));
      chk({name, "_tc"}, 32'(tc), 32'(e[i] == tcv));
    end
  endtask

  initial begin
    run("up", 2'd0, 8, '{0, 1, 2, 3, 4, 5, 0, 1, 0}, 9'b001000000, 5);
    run("down", 2'd1, 8, '{0, 5, 4, 3, 2, 1, 0, 5, 0}, 9'b010000010, 0);
    run("gray", 2'd2, 9, '{0, 1, 3, 2, 6, 7, 5, 4, 0}, 9'b100000000, 4);
    run("lfsr", 2'd3, 9, '{0, 1, 2, 5, 3, 7, 6, 4, 1}, 9'b100000000, 4);
    step(0, 1, 3'd7, 0, 2'd0);
    chk("load7_q", 32'(q), 7);
    step(0, 0, 0, 1, 2'd0);
    chk("oor_up_q", 32'(q), 0);
    chk("oor_up_wrap", 32'(wrap), 0);
    step(0, 1, 3'd5, 0, 2'd0);
    step(0, 0, 0, 1, 2'd0);
    chk("wrap_before_clear", 32'(wrap), 1);
    step(0, 1, 3'd5, 0, 2'd0);
    step(1, 1, 3'd6, 1, 2'd0);
    chk("clr_load_en_q", 32'(q), 0);
    chk("clr_load_en_wrap", 32'(wrap), 0);
    step(0, 1, 3'd2, 1, 2'd0);
    chk("load_beats_en", 32'(q), 2);
    step(0, 1, 3'd7, 0, 2'd1);
    step(0, 0, 0, 1, 2'd1);
    chk("oor_down_q", 32'(q), 5);
    step(1, 0, 0, 0, 2'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 2'd0);
    chk("count_to_3", 32'(q), 3);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 2'd0);
      chk("hold_q", 32'(q), 3);
      chk("hold_wrap", 32'(wrap), 0);
    end
    step(0, 0, 0, 1, 2'd1);
    chk("mode_switch_down", 32'(q), 2);
    step(0, 0, 0, 1, 2'd1);
    step(1, 0, 0, 1, 2'd1);
    chk("clear_mid_q", 32'(q), 0);
    chk("clear_mid_wrap", 32'(wrap), 0);
    @(negedge clk);
    en = 0; mode = 2'd0;
    #1 chk("tc_up_at0", 32'(tc), 0);
    mode = 2'd1;
    #1 chk("tc_down_at0", 32'(tc), 1);
    for (int i = 0; i < 300; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      step(r == 0, r == 1 || r == 2, 3'($urandom_range(0, 7)), r > 4, 2'($urandom_range(0, 3)));
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
